// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   8N1 UART receiver for the LPC COM1 receive path. The asynchronous rx pin
//   is synchronised and oversampled on lpc_clk. Each character is deframed and
//   the byte is presented on rx_data together with a one-clock rx_data_valid
//   strobe, which the LPC rx buffer captures.
//
// Parameters
//   DIVISOR     lpc_clk cycles per oversample tick (1..65535)
//   OVERSAMPLE  ticks per bit (16 only)
//
// Ports
//   lpc_clk        in   system clock, rising edge
//   lpc_rst        in   asynchronous active-low reset
//   rx             in   asynchronous serial line, idle high
//   rx_data        out  [7:0] last correctly received byte
//   rx_data_valid  out  one-clock pulse, new byte on rx_data
//   frame_err      out  one-clock pulse, stop bit sampled low
//   rx_active      out  high while a frame is in progress
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int unsigned DIVISOR    = 18,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       lpc_clk,
    input  logic       lpc_rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    output logic       frame_err,
    output logic       rx_active
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    localparam logic [15:0] PRESCALE_LAST = 16'(DIVISOR - 1);
    localparam logic [3:0]  SAMPLE_LAST   = 4'(OVERSAMPLE - 1);
    // Start bit is checked at its centre: the 8th tick after the falling edge.
    localparam logic [3:0]  SAMPLE_MID    = 4'(OVERSAMPLE / 2 - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic        r_sync1;
    logic        r_rx_s;
    logic [15:0] r_prescale;
    logic [3:0]  r_sample;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;

    logic        w_tick;
    logic        w_start_frame;
    logic        w_enter_data;
    logic        w_shift_en;
    logic        w_valid_set;
    logic        w_err_set;

    assign w_tick    = (r_prescale == PRESCALE_LAST);
    assign rx_active = (r_state == START) || (r_state == DATA) || (r_state == STOP);

    // Two-flop synchroniser. Resets to the idle line level so that leaving
    // reset is never mistaken for a start bit.
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge value of the others.
    always_ff @(posedge lpc_clk or negedge lpc_rst) begin
        if (!lpc_rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rx_s  <= r_sync1;
        end
    end

    always_ff @(posedge lpc_clk or negedge lpc_rst) begin
        if (!lpc_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_next_state  = r_state;
        w_start_frame = 1'b0;
        w_enter_data  = 1'b0;
        w_shift_en    = 1'b0;
        w_valid_set   = 1'b0;
        w_err_set     = 1'b0;

        case (r_state)
            IDLE: begin
                if (!r_rx_s) begin
                    w_next_state  = START;
                    w_start_frame = 1'b1;
                end
            end
            START: begin
                if (w_tick && (r_sample == SAMPLE_MID)) begin
                    if (r_rx_s) begin
                        // Line went back high before mid start bit: glitch.
                        w_next_state = IDLE;
                    end else begin
                        w_next_state = DATA;
                        w_enter_data = 1'b1;
                    end
                end
            end
            DATA: begin
                if (w_tick && (r_sample == SAMPLE_LAST)) begin
                    w_shift_en = 1'b1;
                    if (r_bit == 3'd7) begin
                        w_next_state = STOP;
                    end
                end
            end
            STOP: begin
                if (w_tick && (r_sample == SAMPLE_LAST)) begin
                    if (r_rx_s) begin
                        w_valid_set  = 1'b1;
                        w_next_state = IDLE;
                    end else begin
                        w_err_set    = 1'b1;
                        w_next_state = BREAK;
                    end
                end
            end
            BREAK: begin
                // Hold here while the line stays low so a long break reports
                // a single frame error.
                if (r_rx_s) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Prescaler, sample/bit counters, shift register and registered outputs.
    always_ff @(posedge lpc_clk or negedge lpc_rst) begin
        if (!lpc_rst) begin
            r_prescale    <= '0;
            r_sample      <= '0;
            r_bit         <= '0;
            r_shift       <= '0;
            rx_data       <= '0;
            rx_data_valid <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            // Re-phase the tick grid to the detected falling edge.
            if (w_start_frame || w_tick) begin
                r_prescale <= '0;
            end else begin
                r_prescale <= r_prescale + 16'd1;
            end

            // Cleared again at mid start bit so data samples land on bit
            // centres; otherwise it wraps 15 -> 0 naturally.
            if (w_start_frame || w_enter_data) begin
                r_sample <= '0;
            end else if (w_tick) begin
                r_sample <= r_sample + 4'd1;
            end

            if (w_enter_data) begin
                r_bit <= '0;
            end else if (w_shift_en) begin
                r_bit <= r_bit + 3'd1;
            end

            // LSB arrives first, so shifting in at the MSB leaves the byte in
            // natural order after eight bits.
            if (w_shift_en) begin
                r_shift <= {r_rx_s, r_shift[7:1]};
            end

            if (w_valid_set) begin
                rx_data <= r_shift;
            end
            rx_data_valid <= w_valid_set;
            frame_err     <= w_err_set;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int DIV    = 2;
  localparam int BIT    = DIV * 16;
  localparam int DIV18  = 18;
  localparam int BIT18  = DIV18 * 16;
  localparam int LAT18  = 2 + 1 + DIV18 * (8 + 16 * 9);

  logic       clk = 1'b0;
  logic       lpc_rst;
  logic       rx;
  logic       rx18;

  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       frame_err;
  logic       rx_active;

  logic [7:0] rx_data18;
  logic       rx_data_valid18;
  logic       frame_err18;
  logic       rx_active18;

  always #5 clk = ~clk;

  uart_rx #(.DIVISOR(DIV), .OVERSAMPLE(16)) dut (
    .lpc_clk       (clk),
    .lpc_rst       (lpc_rst),
    .rx            (rx),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .frame_err     (frame_err),
    .rx_active     (rx_active)
  );

  uart_rx #(.DIVISOR(DIV18), .OVERSAMPLE(16)) dut18 (
    .lpc_clk       (clk),
    .lpc_rst       (lpc_rst),
    .rx            (rx18),
    .rx_data       (rx_data18),
    .rx_data_valid (rx_data_valid18),
    .frame_err     (frame_err18),
    .rx_active     (rx_active18)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_v18    = 0;
  int n_e18    = 0;

  // Expected response of one frame: a byte, or a framing error.
  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model_last   = 8'h00;
  logic [7:0] prev_rx_data = 8'h00;
  logic       prev_valid   = 1'b0;
  logic       prev_err     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Hold a line at v for n clocks, changing it on falling clock edges.
  task automatic drive(input bit sel18, input logic v, input int n);
    repeat (n) begin
      @(negedge clk);
      if (sel18) rx18 = v;
      else       rx   = v;
    end
  endtask

  // Send one 8N1 character on rx. A low stop bit is followed by extra_low
  // further low bit-times and then one idle bit-time.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int extra_low);
    exp_t e;
    e.is_err = !stop_bit;
    e.data   = b;
    sb.push_back(e);
    drive(0, 1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(0, b[i], BIT);
    drive(0, stop_bit, BIT);
    if (!stop_bit) begin
      drive(0, 1'b0, BIT * extra_low);
      drive(0, 1'b1, BIT);
    end
  endtask

  // Scoreboard monitor for the DIVISOR=2 instance.
  always @(negedge clk) begin
    if (!lpc_rst) begin
      prev_valid   = 1'b0;
      prev_err     = 1'b0;
      prev_rx_data = 8'h00;
    end else begin
      if (rx_data_valid || frame_err) begin
        check("valid_err_exclusive", 32'(rx_data_valid & frame_err), 32'd0);
        check("active_low_at_pulse", 32'(rx_active), 32'd0);
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: got valid=%0b err=%0b data=%02h, expected no pulse (t=%0t)",
                   rx_data_valid, frame_err, rx_data, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("pulse_kind_err", 32'(frame_err), 32'(e.is_err));
          if (!e.is_err) begin
            check("rx_data", 32'(rx_data), 32'(e.data));
            model_last = e.data;
          end else begin
            check("rx_data_kept_on_err", 32'(rx_data), 32'(model_last));
          end
        end
      end
      if (!rx_data_valid && (rx_data !== prev_rx_data)) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_data_changed_without_valid: got %02h, expected %02h (t=%0t)",
                 rx_data, prev_rx_data, $time);
      end
      if (rx_data_valid) check("valid_width", 32'(prev_valid), 32'd0);
      if (frame_err)     check("err_width", 32'(prev_err), 32'd0);
      prev_valid   = rx_data_valid;
      prev_err     = frame_err;
      prev_rx_data = rx_data;
    end
  end

  always @(negedge clk) begin
    if (lpc_rst) begin
      if (rx_data_valid18) n_v18++;
      if (frame_err18)     n_e18++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    lpc_rst = 1'b0;
    rx      = 1'b1;
    rx18    = 1'b1;
    repeat (3) @(negedge clk);

    check("reset_rx_data",   32'(rx_data),       32'd0);
    check("reset_valid",     32'(rx_data_valid), 32'd0);
    check("reset_frame_err", 32'(frame_err),     32'd0);
    check("reset_active",    32'(rx_active),     32'd0);
    check("reset_active18",  32'(rx_active18),   32'd0);

    @(negedge clk);
    lpc_rst = 1'b1;
    drive(0, 1'b1, 10);

    // Single 0x55 frame; rx_active high mid-frame, low afterwards.
    fork
      send_frame(8'h55, 1'b1, 0);
      begin
        repeat (BIT * 4) @(negedge clk);
        check("active_in_frame", 32'(rx_active), 32'd1);
      end
    join
    check("active_after_frame", 32'(rx_active), 32'd0);
    check("sb_drained_55", 32'(sb.size()), 32'd0);
    drive(0, 1'b1, 20);

    // Back-to-back frames with a single stop bit.
    send_frame(8'hA5, 1'b1, 0);
    send_frame(8'h3C, 1'b1, 0);
    check("sb_drained_b2b", 32'(sb.size()), 32'd0);
    check("rx_data_after_b2b", 32'(rx_data), 32'h3C);
    drive(0, 1'b1, 20);

    // Short low glitch is rejected, then a real frame follows.
    drive(0, 1'b0, 5);
    check("active_during_glitch", 32'(rx_active), 32'd1);
    drive(0, 1'b1, 40);
    check("active_after_glitch", 32'(rx_active), 32'd0);
    check("sb_drained_glitch", 32'(sb.size()), 32'd0);
    send_frame(8'h81, 1'b1, 0);
    check("sb_drained_81", 32'(sb.size()), 32'd0);
    drive(0, 1'b1, 20);

    // Low stop bit then a long break: a single frame error.
    fork
      send_frame(8'h7E, 1'b0, 10);
      begin
        repeat (BIT * 15) @(negedge clk);
        check("active_in_break", 32'(rx_active), 32'd0);
      end
    join
    check("sb_drained_break", 32'(sb.size()), 32'd0);
    check("rx_data_kept_after_break", 32'(rx_data), 32'h81);
    drive(0, 1'b1, 10);
    send_frame(8'h42, 1'b1, 0);
    check("sb_drained_42", 32'(sb.size()), 32'd0);
    drive(0, 1'b1, 20);

    // Reset in the middle of the data bits of 0xFF.
    drive(0, 1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(0, 1'b1, BIT);
    drive(0, 1'b1, BIT / 2);
    check("active_before_reset", 32'(rx_active), 32'd1);
    @(posedge clk);
    #2 lpc_rst = 1'b0;
    #1;
    check("midreset_rx_data", 32'(rx_data),       32'd0);
    check("midreset_valid",   32'(rx_data_valid), 32'd0);
    check("midreset_err",     32'(frame_err),     32'd0);
    check("midreset_active",  32'(rx_active),     32'd0);
    model_last = 8'h00;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    lpc_rst = 1'b1;
    drive(0, 1'b1, 10);
    send_frame(8'h0F, 1'b1, 0);
    check("sb_drained_0f", 32'(sb.size()), 32'd0);
    drive(0, 1'b1, 10);

    // Randomised traffic: good frames, bad stop bits, glitches, random gaps.
    for (int i = 0; i < 14; i++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        drive(0, 1'b0, int'($urandom_range(1, 12)));
        drive(0, 1'b1, BIT + 8);
      end else if (r <= 2) begin
        send_frame(8'($urandom_range(0, 255)), 1'b0, int'($urandom_range(0, 3)));
      end else begin
        send_frame(8'($urandom_range(0, 255)), 1'b1, 0);
      end
      drive(0, 1'b1, int'($urandom_range(0, 40)));
    end
    drive(0, 1'b1, 10);
    check("sb_drained_random", 32'(sb.size()), 32'd0);

    // Full-rate divisor: latency from rx falling edge to rx_data_valid.
    @(negedge clk);
    rx18 = 1'b0;
    fork
      begin
        logic [7:0] b18;
        b18 = 8'hC3;
        drive(1, 1'b0, BIT18 - 1);
        for (int i = 0; i < 8; i++) drive(1, b18[i], BIT18);
        drive(1, 1'b1, BIT18);
      end
      begin
        int cnt;
        int act;
        bit seen;
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < LAT18 + 200) begin
          @(posedge clk);
          cnt++;
          @(negedge clk);
          if (rx_data_valid18) seen = 1'b1;
        end
        check("lat18_valid_seen", 32'(seen), 32'd1);
        if (seen) begin
          act = (cnt >= LAT18 - 2 && cnt <= LAT18 + 2) ? LAT18 : cnt;
          check("lat18_cycles", 32'(act), 32'(LAT18));
          check("rx_data18", 32'(rx_data18), 32'hC3);
        end
      end
    join
    drive(1, 1'b1, 20);

    begin
      int k;
      k = 0;
      while (sb.size() != 0 && k < 500) begin
        @(negedge clk);
        k++;
      end
    end
    check("sb_empty_end", 32'(sb.size()), 32'd0);
    check("valid18_count", 32'(n_v18), 32'd1);
    check("err18_count", 32'(n_e18), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
